mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DataWidth, default 16: memory/requester data width in bits.
REQ-002 Parameter AddrWidth, default 8: memory/requester address width in bits.
REQ-003 Parameter AccessCycles, default 1, legal range 1..15: clocks the memory is driven per transaction.
REQ-004 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  CPU transaction request, held high until cpu_ack.
REQ-007 cpu_wr  input  1  CPU direction: 1 = write, 0 = read.
REQ-008 cpu_addr  input  AddrWidth  CPU address.
REQ-009 cpu_wdata  input  DataWidth  CPU write data.
REQ-010 cpu_ack  output  1  one-cycle pulse: CPU transaction complete.
REQ-011 cpu_rdata  output  DataWidth  CPU read data, valid in the cpu_ack cycle and held until the next CPU read ack.
REQ-012 dma_req, dma_wr, dma_addr, dma_wdata, dma_ack, dma_rdata: same directions, widths and meanings as REQ-006..REQ-011, for the loader/DMA port.
REQ-013 mem_addr  output  AddrWidth  address to the shared memory.
REQ-014 mem_wdata  output  DataWidth  write data to the shared memory.
REQ-015 mem_wr  output  1  memory write strobe.
REQ-016 mem_rdata  input  DataWidth  combinational read data from the shared memory.
REQ-017 busy  output  1  high whenever the state is not S_Idle.

Function
REQ-018 The FSM SHALL have the states S_Idle, S_Cpu and S_Dma.
REQ-019 In S_Idle with any request high, the arbiter SHALL select a winner, latch its wr/addr/wdata into internal registers, load the cycle counter with AccessCycles-1, and enter S_Cpu or S_Dma on the next edge.
REQ-020 In S_Idle with no request high, the FSM SHALL remain in S_Idle.
REQ-021 When both requests are high in S_Idle, fixed priority SHALL grant the CPU (see REQ-032 for the alternative).
REQ-022 In S_Cpu/S_Dma, mem_addr and mem_wdata SHALL come from the latched registers, and mem_wr SHALL equal the latched wr bit for every access cycle.
REQ-023 The counter SHALL decrement once per access cycle; in the cycle it reads 0, the granted ack SHALL pulse high for exactly one cycle, the corresponding rdata SHALL register mem_rdata (reads only), and the next state SHALL be S_Idle.
REQ-024 Transaction latency from request sampled in S_Idle to ack SHALL be AccessCycles+1 clocks; back-to-back requests SHALL therefore complete every AccessCycles+1 clocks.
REQ-025 Requester inputs SHALL be ignored while not in S_Idle; a request dropped mid-access SHALL still complete, and ack SHALL still pulse.
REQ-026 The non-granted ack SHALL remain low; both acks SHALL never be high in the same cycle.
REQ-027 In S_Idle, mem_wr SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-028 A requester SHALL drop req in the cycle after ack; a req still high then is treated as a new transaction.

Reset
REQ-029 Reset high at a posedge SHALL force S_Idle, zero the counter, the latched registers, mem_addr, mem_wdata and both rdata outputs, drive mem_wr=0, cpu_ack=0, dma_ack=0 and busy=0, and clear the round-robin pointer to "DMA last".
REQ-030 Reset asserted mid-transaction SHALL abort it with no ack; mem_wr SHALL be 0 from the following cycle.
REQ-031 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined, a one-bit last-grant register SHALL be updated at each grant, and on a tie the requester not granted last SHALL win; without it, the register SHALL not exist and the CPU SHALL always win ties.

Verification
REQ-033 Reset, then a CPU read of addr 0x03 with mem[0x03]=0x1234 and AccessCycles=1 -> cpu_ack high 2 clocks after the request is sampled, cpu_rdata=0x1234, mem_wr=0 throughout.
REQ-034 A DMA write of 0xBEEF to 0x0A with AccessCycles=3 -> mem_wr high for exactly 3 cycles with mem_addr=0x0A and mem_wdata=0xBEEF, then dma_ack pulses once and busy falls.
REQ-035 cpu_req and dma_req held high together for 4 transactions -> without the macro all 4 grants go to the CPU; with ARB_ROUND_ROBIN_EN the grants go CPU, DMA, CPU, DMA.
REQ-036 Reset pulsed during the second access cycle of a DMA write with AccessCycles=3 -> no dma_ack, mem_wr=0 and busy=0 from the next cycle, and the FSM is in S_Idle.
REQ-037 cpu_req dropped after one cycle of a CPU read with AccessCycles=2 -> cpu_ack still pulses once, and dma_req raised during the access is granted only after S_Idle is re-entered.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter in front of a single-port shared memory.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of always going to the CPU.
module mem_arbiter #(
    parameter int unsigned DataWidth    = 16,
    parameter int unsigned AddrWidth    = 8,
    parameter int unsigned AccessCycles = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [AddrWidth-1:0] cpu_addr,
    input  logic [DataWidth-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [DataWidth-1:0] cpu_rdata,
    input  logic                 dma_req,
    input  logic                 dma_wr,
    input  logic [AddrWidth-1:0] dma_addr,
    input  logic [DataWidth-1:0] dma_wdata,
    output logic                 dma_ack,
    output logic [DataWidth-1:0] dma_rdata,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic                 mem_wr,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_Idle = 2'd0,
        S_Cpu  = 2'd1,
        S_Dma  = 2'd2
    } state_e;

    localparam logic [3:0] CntLoad = 4'(AccessCycles - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic                 dma_ack_q, dma_ack_d;
    logic [DataWidth-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DataWidth-1:0] dma_rdata_q, dma_rdata_d;
    logic                 grant_cpu;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dma_q, last_dma_d;

    // On a tie the CPU wins only if the DMA was the last one served.
    assign grant_cpu = cpu_req && (!dma_req || last_dma_q);
`else
    assign grant_cpu = cpu_req;
`endif

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through this block infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_dma_d  = last_dma_q;
`endif
        case (state_q)
            S_Idle: begin
                if (grant_cpu) begin
                    state_d = S_Cpu;
                    cnt_d   = CntLoad;
                    wr_d    = cpu_wr;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dma_d = 1'b0;
`endif
                end else if (dma_req) begin
                    state_d = S_Dma;
                    cnt_d   = CntLoad;
                    wr_d    = dma_wr;
                    addr_d  = dma_addr;
                    wdata_d = dma_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dma_d = 1'b1;
`endif
                end
            end
            S_Cpu, S_Dma: begin
                // Last access cycle: ack and read data are registered so they appear with the return to idle.
                if (cnt_q == 4'd0) begin
                    state_d = S_Idle;
                    if (state_q == S_Cpu) begin
                        cpu_ack_d = 1'b1;
                        if (!wr_q) cpu_rdata_d = mem_rdata;
                    end else begin
                        dma_ack_d = 1'b1;
                        if (!wr_q) dma_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_Idle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_Idle;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of every other one.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= last_dma_d;
`endif
        end
    end

    // The latched address/data only change on a grant, so they also hold the last values while idle.
    assign busy      = (state_q != S_Idle);
    assign mem_wr    = busy && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances with AccessCycles = 1, 2, 3 sharing one clock,
// each with its own behavioural memory; a transaction-level model checks randomized traffic.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        cpu_req   [3];
    logic        cpu_wr    [3];
    logic [7:0]  cpu_addr  [3];
    logic [15:0] cpu_wdata [3];
    logic        cpu_ack   [3];
    logic [15:0] cpu_rdata [3];
    logic        dma_req   [3];
    logic        dma_wr    [3];
    logic [7:0]  dma_addr  [3];
    logic [15:0] dma_wdata [3];
    logic        dma_ack   [3];
    logic [15:0] dma_rdata [3];
    logic [7:0]  mem_addr  [3];
    logic [15:0] mem_wdata [3];
    logic        mem_wr    [3];
    logic [15:0] mem_rdata [3];
    logic        busy      [3];

    logic [15:0] mem     [3][256];
    bit          written [3][256];
    logic        pre_we = 1'b0;
    int          pre_k  = 0;
    logic [7:0]  pre_a  = 8'd0;
    logic [15:0] pre_d  = 16'd0;

    logic [15:0] ref_mem [int];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a ^ 8'hA5, a};
    endfunction

    function automatic logic [15:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(8'(a));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .DataWidth   (16),
            .AddrWidth   (8),
            .AccessCycles(g + 1)
        ) dut (
            .Clk      (clk),
            .Reset    (rst[g]),
            .cpu_req  (cpu_req[g]),
            .cpu_wr   (cpu_wr[g]),
            .cpu_addr (cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]),
            .cpu_ack  (cpu_ack[g]),
            .cpu_rdata(cpu_rdata[g]),
            .dma_req  (dma_req[g]),
            .dma_wr   (dma_wr[g]),
            .dma_addr (dma_addr[g]),
            .dma_wdata(dma_wdata[g]),
            .dma_ack  (dma_ack[g]),
            .dma_rdata(dma_rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_wr   (mem_wr[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
        assign mem_rdata[g] = written[g][mem_addr[g]] ? mem[g][mem_addr[g]] : pat(mem_addr[g]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_wr[k] === 1'b1) begin
                mem[k][mem_addr[k]]     <= mem_wdata[k];
                written[k][mem_addr[k]] <= 1'b1;
            end
        end
        if (pre_we) begin
            mem[pre_k][pre_a]     <= pre_d;
            written[pre_k][pre_a] <= 1'b1;
        end
    end

    task automatic do_reset(input int k);
        @(negedge clk);
        cpu_req[k] = 1'b0;
        dma_req[k] = 1'b0;
        rst[k]     = 1'b1;
        @(negedge clk);
        rst[k]     = 1'b0;
    endtask

    task automatic preload(input int k, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_k  = k;
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] got;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            cpu_req[k]   = 1'b1;
            dma_req[k]   = 1'b1;
            cpu_wr[k]    = 1'b1;
            dma_wr[k]    = 1'b1;
            cpu_addr[k]  = 8'hFF;
            dma_addr[k]  = 8'hFF;
            cpu_wdata[k] = 16'hFFFF;
            dma_wdata[k] = 16'hFFFF;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            got = {busy[k], cpu_ack[k], dma_ack[k], mem_wr[k], mem_addr[k],
                   mem_wdata[k], cpu_rdata[k], dma_rdata[k]};
            n_checks++;
            if (got !== 60'd0) $display("FAIL reset_outputs[%0d]: got %h, want 0", k, got);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            cpu_req[k]   = 1'b0;
            dma_req[k]   = 1'b0;
            cpu_wr[k]    = 1'b0;
            dma_wr[k]    = 1'b0;
            cpu_addr[k]  = 8'h00;
            dma_addr[k]  = 8'h00;
            cpu_wdata[k] = 16'h0000;
            dma_wdata[k] = 16'h0000;
            rst[k]       = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy[k] !== 1'b0) $display("FAIL idle_no_req[%0d]: busy=%b, want 0", k, busy[k]);
            else n_pass++;
        end
    endtask

    task automatic test_cpu_read();
        int n = 0;
        int wr_seen = 0;
        preload(0, 8'h03, 16'h1234);
        cpu_req[0]  = 1'b1;
        cpu_wr[0]   = 1'b0;
        cpu_addr[0] = 8'h03;
        do begin
            @(negedge clk);
            n++;
            if (mem_wr[0] !== 1'b0) wr_seen++;
        end while (cpu_ack[0] !== 1'b1 && n < 8);
        cpu_req[0] = 1'b0;
        n_checks++;
        if (n !== 2) $display("FAIL cpu_read_latency: ack after %0d clocks, want 2", n);
        else n_pass++;
        n_checks++;
        if (cpu_rdata[0] !== 16'h1234) $display("FAIL cpu_read_data: got %h, want 1234", cpu_rdata[0]);
        else n_pass++;
        n_checks++;
        if (wr_seen !== 0) $display("FAIL cpu_read_mem_wr: mem_wr high %0d cycles, want 0", wr_seen);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({cpu_ack[0], cpu_rdata[0]} !== {1'b0, 16'h1234})
            $display("FAIL cpu_read_hold: ack=%b rdata=%h, want ack=0 rdata=1234", cpu_ack[0], cpu_rdata[0]);
        else n_pass++;
    endtask

    task automatic test_dma_write();
        int n = 0;
        int wr_cycles = 0;
        int bad = 0;
        do_reset(2);
        dma_req[2]   = 1'b1;
        dma_wr[2]    = 1'b1;
        dma_addr[2]  = 8'h0A;
        dma_wdata[2] = 16'hBEEF;
        do begin
            @(negedge clk);
            n++;
            if (mem_wr[2] === 1'b1) begin
                wr_cycles++;
                if (mem_addr[2] !== 8'h0A || mem_wdata[2] !== 16'hBEEF) bad++;
            end
        end while (dma_ack[2] !== 1'b1 && n < 10);
        dma_req[2] = 1'b0;
        n_checks++;
        if (wr_cycles !== 3 || bad !== 0)
            $display("FAIL dma_write_strobe: mem_wr cycles=%0d bad=%0d, want 3 and 0", wr_cycles, bad);
        else n_pass++;
        n_checks++;
        if (n !== 4 || cpu_ack[2] !== 1'b0)
            $display("FAIL dma_write_ack: ack after %0d clocks cpu_ack=%b, want 4 and 0", n, cpu_ack[2]);
        else n_pass++;
        n_checks++;
        if (busy[2] !== 1'b0) $display("FAIL dma_write_busy: busy=%b in ack cycle, want 0", busy[2]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({dma_ack[2], busy[2]} !== 2'b00)
            $display("FAIL dma_write_once: ack=%b busy=%b, want 00", dma_ack[2], busy[2]);
        else n_pass++;
        n_checks++;
        if (mem[2][8'h0A] !== 16'hBEEF) $display("FAIL dma_write_mem: got %h, want beef", mem[2][8'h0A]);
        else n_pass++;
    endtask

    task automatic test_tie();
        bit last_dma = 1'b1;
        bit exp_cpu;
        int n;
        logic [15:0] rd;
        logic [15:0] exp_rd;
        do_reset(0);
        cpu_req[0]  = 1'b1;
        cpu_wr[0]   = 1'b0;
        cpu_addr[0] = 8'h10;
        dma_req[0]  = 1'b1;
        dma_wr[0]   = 1'b0;
        dma_addr[0] = 8'h20;
        for (int t = 0; t < 4; t++) begin
            exp_cpu = RrEn ? last_dma : 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (cpu_ack[0] !== 1'b1 && dma_ack[0] !== 1'b1 && n < 8);
            n_checks++;
            if ({cpu_ack[0], dma_ack[0]} !== {exp_cpu, !exp_cpu} || n !== 2)
                $display("FAIL tie_grant[%0d]: cpu_ack=%b dma_ack=%b after %0d, want %b %b after 2",
                         t, cpu_ack[0], dma_ack[0], n, exp_cpu, !exp_cpu);
            else n_pass++;
            rd     = exp_cpu ? cpu_rdata[0] : dma_rdata[0];
            exp_rd = exp_cpu ? pat(8'h10) : pat(8'h20);
            n_checks++;
            if (rd !== exp_rd) $display("FAIL tie_rdata[%0d]: got %h, want %h", t, rd, exp_rd);
            else n_pass++;
            last_dma = !exp_cpu;
            if (t == 3) begin
                cpu_req[0] = 1'b0;
                dma_req[0] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        int busy_seen = 0;
        do_reset(2);
        dma_req[2]   = 1'b1;
        dma_wr[2]    = 1'b1;
        dma_addr[2]  = 8'h0B;
        dma_wdata[2] = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        rst[2]     = 1'b1;
        dma_req[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy[2], mem_wr[2], dma_ack[2]} !== 3'b000)
            $display("FAIL abort_outputs: busy=%b mem_wr=%b ack=%b, want 000", busy[2], mem_wr[2], dma_ack[2]);
        else n_pass++;
        n_checks++;
        if (mem_addr[2] !== 8'h00) $display("FAIL abort_addr: got %h, want 00", mem_addr[2]);
        else n_pass++;
        rst[2] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (dma_ack[2] === 1'b1) acks++;
            if (busy[2] !== 1'b0) busy_seen++;
        end
        n_checks++;
        if (acks !== 0 || busy_seen !== 0)
            $display("FAIL abort_no_ack: acks=%0d busy cycles=%0d, want 0 and 0", acks, busy_seen);
        else n_pass++;
    endtask

    task automatic test_random();
        bit hold_c = 1'b0;
        bit hold_d = 1'b0;
        bit last_dma = 1'b1;
        bit win_cpu;
        logic        c_wr = 1'b0, d_wr = 1'b0, w_wr;
        logic [7:0]  c_addr = 8'h0, d_addr = 8'h0, w_addr;
        logic [15:0] c_wd = 16'h0, d_wd = 16'h0, w_wd, exp_rd, rd;
        int n, wr_cycles, addr_bad, both;
        do_reset(1);
        for (int it = 0; it < 40; it++) begin
            if (!hold_c && $urandom_range(1, 0) == 1) begin
                hold_c = 1'b1;
                c_wr   = 1'($urandom_range(1, 0));
                c_addr = 8'($urandom_range(15, 0));
                c_wd   = 16'($urandom);
            end
            if (!hold_d && $urandom_range(1, 0) == 1) begin
                hold_d = 1'b1;
                d_wr   = 1'($urandom_range(1, 0));
                d_addr = 8'($urandom_range(15, 0));
                d_wd   = 16'($urandom);
            end
            if (!hold_c && !hold_d) begin
                hold_c = 1'b1;
                c_wr   = 1'($urandom_range(1, 0));
                c_addr = 8'($urandom_range(15, 0));
                c_wd   = 16'($urandom);
            end
            cpu_req[1] = hold_c; cpu_wr[1] = c_wr; cpu_addr[1] = c_addr; cpu_wdata[1] = c_wd;
            dma_req[1] = hold_d; dma_wr[1] = d_wr; dma_addr[1] = d_addr; dma_wdata[1] = d_wd;
            win_cpu = hold_c && (!hold_d || !RrEn || last_dma);
            w_wr    = win_cpu ? c_wr : d_wr;
            w_addr  = win_cpu ? c_addr : d_addr;
            w_wd    = win_cpu ? c_wd : d_wd;
            exp_rd  = ref_read(int'(w_addr));
            if (w_wr) ref_mem[int'(w_addr)] = w_wd;
            n = 0; wr_cycles = 0; addr_bad = 0; both = 0;
            do begin
                @(negedge clk);
                n++;
                if (cpu_ack[1] === 1'b1 && dma_ack[1] === 1'b1) both++;
                if (mem_wr[1] === 1'b1) begin
                    wr_cycles++;
                    if (mem_addr[1] !== w_addr || mem_wdata[1] !== w_wd) addr_bad++;
                end
            end while (cpu_ack[1] !== 1'b1 && dma_ack[1] !== 1'b1 && n < 8);
            n_checks++;
            if ({cpu_ack[1], dma_ack[1]} !== {win_cpu, !win_cpu} || n !== 3)
                $display("FAIL rand_grant[%0d]: cpu_ack=%b dma_ack=%b after %0d, want %b %b after 3",
                         it, cpu_ack[1], dma_ack[1], n, win_cpu, !win_cpu);
            else n_pass++;
            n_checks++;
            if (wr_cycles !== (w_wr ? 2 : 0) || addr_bad !== 0 || both !== 0)
                $display("FAIL rand_mem[%0d]: wr cycles=%0d bad=%0d both=%0d, want %0d 0 0",
                         it, wr_cycles, addr_bad, both, w_wr ? 2 : 0);
            else n_pass++;
            if (!w_wr) begin
                rd = win_cpu ? cpu_rdata[1] : dma_rdata[1];
                n_checks++;
                if (rd !== exp_rd) $display("FAIL rand_rdata[%0d]: got %h, want %h", it, rd, exp_rd);
                else n_pass++;
            end
            last_dma = RrEn ? !win_cpu : last_dma;
            if (win_cpu) begin
                hold_c = 1'b0;
                cpu_req[1] = 1'b0;
            end else begin
                hold_d = 1'b0;
                dma_req[1] = 1'b0;
            end
        end
        cpu_req[1] = 1'b0;
        dma_req[1] = 1'b0;
    endtask

    task automatic test_drop_mid();
        int cpu_acks = 0, dma_acks = 0;
        int cpu_n = 0, dma_n = 0, early = 0;
        logic [15:0] exp_rd;
        do_reset(1);
        exp_rd      = ref_read(8'h40);
        cpu_req[1]  = 1'b1;
        cpu_wr[1]   = 1'b0;
        cpu_addr[1] = 8'h40;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cpu_req[1]   = 1'b0;
                dma_req[1]   = 1'b1;
                dma_wr[1]    = 1'b1;
                dma_addr[1]  = 8'h41;
                dma_wdata[1] = 16'hCAFE;
            end
            if (cpu_ack[1] === 1'b1) begin
                cpu_acks++;
                cpu_n = n;
                if (cpu_rdata[1] !== exp_rd) early += 100;
            end
            if (dma_ack[1] === 1'b1) begin
                dma_acks++;
                dma_n = n;
                if (cpu_acks == 0) early++;
                dma_req[1] = 1'b0;
            end
        end
        n_checks++;
        if (cpu_acks !== 1 || cpu_n !== 3)
            $display("FAIL drop_cpu_ack: acks=%0d at %0d, want 1 at 3", cpu_acks, cpu_n);
        else n_pass++;
        n_checks++;
        if (cpu_rdata[1] !== exp_rd) $display("FAIL drop_cpu_rdata: got %h, want %h", cpu_rdata[1], exp_rd);
        else n_pass++;
        n_checks++;
        if (dma_acks !== 1 || dma_n !== 6 || early !== 0)
            $display("FAIL drop_dma_after_idle: acks=%0d at %0d early=%0d, want 1 at 6 early 0",
                     dma_acks, dma_n, early);
        else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            cpu_req[k]   = 1'b0;
            cpu_wr[k]    = 1'b0;
            cpu_addr[k]  = 8'h00;
            cpu_wdata[k] = 16'h0000;
            dma_req[k]   = 1'b0;
            dma_wr[k]    = 1'b0;
            dma_addr[k]  = 8'h00;
            dma_wdata[k] = 16'h0000;
        end
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_tie();
        test_reset_abort();
        test_random();
        test_drop_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
